// File: rtl/pc_sequencer_if.sv
// Front-end bus bundle for pc_sequencer: fetch req/ack, decode valid/ready,
// next-PC mux select/return and control/status lines.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_inc;
    logic [1:0]       mux_sel;
    logic [WIDTH-1:0] next_pc;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_data;
    logic             instr_valid;
    logic [WIDTH-1:0] instr_out;
    logic             instr_ready;
    logic             branch_taken;
    logic             jump;
    logic             halt;
    logic             halted;
    logic             fault;

    modport master (
        output pc, pc_inc, mux_sel, imem_req, imem_addr,
        output instr_valid, instr_out, halted, fault,
        input  next_pc, imem_ack, imem_data, instr_ready,
        input  branch_taken, jump, halt
    );

    modport slave (
        input  pc, pc_inc, mux_sel, imem_req, imem_addr,
        input  instr_valid, instr_out, halted, fault,
        output next_pc, imem_ack, imem_data, instr_ready,
        output branch_taken, jump, halt
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: fetch (req/ack) then hand-off to decode (valid/ready).
// Optional fetch watchdog enabled by defining PC_WATCHDOG_EN.
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("pc_sequencer: TIMEOUT must be 1..255");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic             xfer;

`ifdef PC_WATCHDOG_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
`endif

    assign xfer = valid_q & bus.instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
`ifdef PC_WATCHDOG_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
`ifdef PC_WATCHDOG_EN
                cnt_d   = 8'd0;
`endif
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
`ifdef PC_WATCHDOG_EN
                else if (cnt_q + 8'd1 == TMO) begin
                    cnt_d   = cnt_q + 8'd1;
                    fault_d = 1'b1;
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            HOLD: begin
                if (xfer) begin
                    pc_d    = bus.next_pc;
                    valid_d = 1'b0;
                    state_d = bus.halt ? HALTED : FETCH;
`ifdef PC_WATCHDOG_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            HALTED: begin
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

`ifdef PC_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
`endif

    // Jump outranks branch when both are raised in the same transfer.
    assign bus.mux_sel     = bus.jump         ? 2'b10 :
                             bus.branch_taken ? 2'b01 : 2'b00;
    assign bus.pc          = pc_q;
    assign bus.pc_inc      = pc_q + WIDTH'(1);
    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_out   = instr_q;
    assign bus.halted      = (state_q == HALTED);
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written
// halt, watchdog and reset sequences.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(16)) bif ();

    pc_sequencer #(
        .WIDTH(16),
        .RESET_VECTOR(16'h0000),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif.master)
    );

    logic [15:0] btgt, jtgt;

    // Models the external 3:1 next-PC multiplexer.
    always_comb begin
        case (bif.mux_sel)
            2'b10:   bif.next_pc = jtgt;
            2'b01:   bif.next_pc = btgt;
            default: bif.next_pc = bif.pc_inc;
        endcase
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
        int          ack_dly;
        int          rdy_dly;
        logic        br;
        logic        jmp;
        logic        hlt;
        logic [15:0] tgt;
        logic [1:0]  exp_sel;
        logic [15:0] exp_pc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bif.imem_req && n < 50) begin
            step();
            n++;
        end
        chk("req_wait", 32'(bif.imem_req), 32'd1);
    endtask

    task automatic xact(input vec_t v);
        logic [15:0] inc;
        wait_req();
        chk("imem_addr", 32'(bif.imem_addr), 32'(v.pc));
        for (int i = 0; i < v.ack_dly; i++) begin
            step();
            chk("req_held", 32'(bif.imem_req), 32'd1);
        end
        bif.imem_ack  = 1'b1;
        bif.imem_data = v.data;
        step();
        bif.imem_ack  = 1'b0;
        bif.imem_data = 16'hBAD0;
        chk("valid_set", 32'(bif.instr_valid), 32'd1);
        chk("instr_out", 32'(bif.instr_out), 32'(v.data));
        for (int i = 0; i < v.rdy_dly; i++) begin
            bif.branch_taken = 1'b1;
            bif.imem_ack     = 1'b1;
            btgt             = 16'h7777;
            step();
            chk("stall_valid", 32'(bif.instr_valid), 32'd1);
            chk("stall_instr", 32'(bif.instr_out), 32'(v.data));
            chk("stall_pc", 32'(bif.pc), 32'(v.pc));
        end
        bif.imem_ack     = 1'b0;
        bif.branch_taken = v.br;
        bif.jump         = v.jmp;
        bif.halt         = v.hlt;
        btgt             = v.jmp ? ~v.tgt : v.tgt;
        jtgt             = v.jmp ? v.tgt : ~v.tgt;
        bif.instr_ready  = 1'b1;
        #1;
        inc = v.pc + 16'd1;
        chk("mux_sel", 32'(bif.mux_sel), 32'(v.exp_sel));
        chk("pc_inc", 32'(bif.pc_inc), 32'(inc));
        step();
        bif.instr_ready  = 1'b0;
        bif.branch_taken = 1'b0;
        bif.jump         = 1'b0;
        bif.halt         = 1'b0;
        chk("pc_after", 32'(bif.pc), 32'(v.exp_pc));
        chk("valid_clr", 32'(bif.instr_valid), 32'd0);
    endtask

    vec_t vecs[9];
    vec_t v;
    int   n;

    initial begin
        bif.imem_ack     = 1'b0;
        bif.imem_data    = 16'h0000;
        bif.instr_ready  = 1'b0;
        bif.branch_taken = 1'b0;
        bif.jump         = 1'b0;
        bif.halt         = 1'b0;
        btgt             = 16'h0000;
        jtgt             = 16'h0000;

        //         pc       data     ack rdy br    jmp   hlt   tgt      sel    exp_pc
        vecs[0] = '{16'h0000, 16'h1111, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0001};
        vecs[1] = '{16'h0001, 16'h2222, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0002};
        vecs[2] = '{16'h0002, 16'h3333, 0, 0, 1'b1, 1'b0, 1'b0, 16'h0040, 2'b01, 16'h0040};
        vecs[3] = '{16'h0040, 16'h4444, 1, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0041};
        vecs[4] = '{16'h0041, 16'h5555, 0, 0, 1'b1, 1'b1, 1'b0, 16'h1234, 2'b10, 16'h1234};
        vecs[5] = '{16'h1234, 16'h6666, 0, 1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 2'b10, 16'hFFFF};
        vecs[6] = '{16'hFFFF, 16'h7777, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000};
        vecs[7] = '{16'h0000, 16'h8888, 3, 5, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0001};
        vecs[8] = '{16'h0001, 16'h9999, 0, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h0002};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 32'(bif.pc), 32'h0000);
        chk("rst_req", 32'(bif.imem_req), 32'd0);
        chk("rst_valid", 32'(bif.instr_valid), 32'd0);
        chk("rst_instr", 32'(bif.instr_out), 32'h0000);
        chk("rst_halted", 32'(bif.halted), 32'd0);
        chk("rst_fault", 32'(bif.fault), 32'd0);
        rst_n = 1'b1;
        chk("idle_bubble", 32'(bif.imem_req), 32'd0);

        for (int i = 0; i < 9; i++) xact(vecs[i]);

        chk("halted", 32'(bif.halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            bif.imem_ack = 1'b1;
            bif.instr_ready = 1'b1;
            step();
            chk("halt_req", 32'(bif.imem_req), 32'd0);
        end
        bif.imem_ack = 1'b0;
        bif.instr_ready = 1'b0;
        chk("halt_pc", 32'(bif.pc), 32'h0002);
        chk("halt_valid", 32'(bif.instr_valid), 32'd0);

        #2 rst_n = 1'b0;
        #1;
        chk("rst2_halted", 32'(bif.halted), 32'd0);
        chk("rst2_pc", 32'(bif.pc), 32'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef PC_WATCHDOG_EN
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bif.fault) break;
            if (bif.imem_req) n++;
            step();
        end
        chk("wd_fetch_cycles", 32'(n), 32'd8);
        chk("wd_fault", 32'(bif.fault), 32'd1);
        chk("wd_halted", 32'(bif.halted), 32'd1);
        chk("wd_req", 32'(bif.imem_req), 32'd0);
        repeat (3) step();
        chk("wd_sticky", 32'(bif.fault), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("wd_rst_fault", 32'(bif.fault), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        v = '{16'h0000, 16'hABCD, 7, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0001};
        xact(v);
        chk("wd_ack_wins", 32'(bif.fault), 32'd0);
`else
        v = '{16'h0000, 16'hABCD, 300, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0001};
        xact(v);
        chk("no_wd_fault", 32'(bif.fault), 32'd0);
`endif

        wait_req();
        step();
        step();
        chk("fetch_pc", 32'(bif.pc), 32'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("midfetch_pc", 32'(bif.pc), 32'h0000);
        chk("midfetch_fault", 32'(bif.fault), 32'd0);
        chk("midfetch_req", 32'(bif.imem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
